// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receive path.
// Latency: n/a (types only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } rx_state_e;

    localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
    localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
    localparam int         PS2_FRAME_BITS = 11;

    // Odd parity over data+parity and a high stop bit make a good frame.
    function automatic logic ps2_frame_ok(input logic [7:0] data,
                                          input logic       parity,
                                          input logic       stop);
        return (^{data, parity}) & stop;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes an async PS/2 line, debounces it, and flags filtered falling edges.
// Latency: SYNC_STAGES+FILTER_CYCLES cycles from pin edge to dout/fall_stb.
// Backpressure: none; fall_stb is a single-cycle strobe.
module ps2_line_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic fall_stb
);

    localparam int CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q   <= '1;
            dout     <= 1'b1;
            cnt_q    <= '0;
            fall_stb <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            fall_stb <= 1'b0;
            // Level flips only after FILTER_CYCLES consecutive differing samples.
            if (sync_out != dout) begin
                if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                    dout     <= sync_out;
                    cnt_q    <= '0;
                    fall_stb <= dout & ~sync_out;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 device-to-host frame receiver folding E0/F0 prefixes into key events.
// Latency: SYNC_STAGES+FILTER_CYCLES+2 cycles from stop-bit pin fall to key_valid/frame_err.
// Backpressure: none; key_valid must be consumed in the cycle it is high.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_break,
    output logic       key_extended,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [3:0] STOP_IDX = 4'(PS2_FRAME_BITS - 1);

    logic                   clk_filt;
    logic                   clk_fall;
    logic                   fall;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   data_bit;

    rx_state_e   state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [7:0]  sreg, sreg_n;
    logic        par_q, par_n;
    logic        stop_q, stop_n;
    logic [TO_W-1:0] tcnt, tcnt_n;
    logic        ext_pend, ext_n;
    logic        brk_pend, brk_n;
    logic        key_valid_n, frame_err_n;
    logic [7:0]  key_code_n;
    logic        key_break_n, key_extended_n;

    ps2_line_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_clk_filter (
        .clk      (clk),
        .reset    (reset),
        .din      (ps2_clk),
        .dout     (clk_filt),
        .fall_stb (clk_fall)
    );

    // Data gets the same synchronizer depth so both lines see equal pin-to-core delay.
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_sync <= '1;
        end else begin
            data_sync[0] <= ps2_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync[i] <= data_sync[i-1];
            end
        end
    end

    assign data_bit = data_sync[SYNC_STAGES-1];
    assign fall     = clk_fall & ~clk_filt;
    assign rx_busy  = (state == SHIFT);

    always_comb begin
        state_n        = state;
        bit_cnt_n      = bit_cnt;
        sreg_n         = sreg;
        par_n          = par_q;
        stop_n         = stop_q;
        tcnt_n         = tcnt;
        ext_n          = ext_pend;
        brk_n          = brk_pend;
        key_valid_n    = 1'b0;
        frame_err_n    = 1'b0;
        key_code_n     = key_code;
        key_break_n    = key_break;
        key_extended_n = key_extended;

        case (state)
            IDLE: begin
                tcnt_n = '0;
                if (fall) begin
                    if (!data_bit) begin
                        state_n   = SHIFT;
                        bit_cnt_n = 4'd1;
                        tcnt_n    = TO_W'(1);
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (fall) begin
                    tcnt_n    = TO_W'(1);
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt <= 4'd8) begin
                        sreg_n = {data_bit, sreg[7:1]};
                    end else if (bit_cnt < STOP_IDX) begin
                        par_n = data_bit;
                    end else begin
                        stop_n  = data_bit;
                        state_n = CHECK;
                    end
                end else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // tcnt started at 1 on the last strobe, so this lands TIMEOUT_CYCLES after it.
                    frame_err_n = 1'b1;
                    ext_n       = 1'b0;
                    brk_n       = 1'b0;
                    bit_cnt_n   = 4'd0;
                    state_n     = IDLE;
                end else begin
                    tcnt_n = tcnt + TO_W'(1);
                end
            end
            CHECK: begin
                state_n   = IDLE;
                bit_cnt_n = 4'd0;
                if (!ps2_frame_ok(sreg, par_q, stop_q)) begin
                    frame_err_n = 1'b1;
                    ext_n       = 1'b0;
                    brk_n       = 1'b0;
                end else if (sreg == PS2_EXT_PREFIX) begin
                    ext_n = 1'b1;
                end else if (sreg == PS2_BRK_PREFIX) begin
                    brk_n = 1'b1;
                end else begin
                    key_valid_n    = 1'b1;
                    key_code_n     = sreg;
                    key_break_n    = brk_pend;
                    key_extended_n = ext_pend;
                    ext_n          = 1'b0;
                    brk_n          = 1'b0;
                end
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            bit_cnt      <= 4'd0;
            sreg         <= 8'd0;
            par_q        <= 1'b0;
            stop_q       <= 1'b0;
            tcnt         <= '0;
            ext_pend     <= 1'b0;
            brk_pend     <= 1'b0;
            key_valid    <= 1'b0;
            frame_err    <= 1'b0;
            key_code     <= 8'd0;
            key_break    <= 1'b0;
            key_extended <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            sreg         <= sreg_n;
            par_q        <= par_n;
            stop_q       <= stop_n;
            tcnt         <= tcnt_n;
            ext_pend     <= ext_n;
            brk_pend     <= brk_n;
            key_valid    <= key_valid_n;
            frame_err    <= frame_err_n;
            key_code     <= key_code_n;
            key_break    <= key_break_n;
            key_extended <= key_extended_n;
        end
    end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed plus randomized frames against a byte-level model of prefix folding and framing.
module tb_ps2_key_receiver;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int TO   = 1000;
    localparam int HP   = 20;
    localparam int LAT  = SYNC + FILT + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_break;
    logic       key_extended;
    logic       frame_err;
    logic       rx_busy;

    always #5 clk = ~clk;

    ps2_key_receiver #(
        .SYNC_STAGES    (SYNC),
        .FILTER_CYCLES  (FILT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .key_break    (key_break),
        .key_extended (key_extended),
        .frame_err    (frame_err),
        .rx_busy      (rx_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        logic       brk;
        logic       ext;
        int         at;
    } ev_t;

    ev_t obs_q[$];
    int  busy_cycles = 0;
    int  both_cnt = 0;

    always @(negedge clk) begin
        if (key_valid === 1'b1) obs_q.push_back('{1'b0, key_code, key_break, key_extended, cyc});
        if (frame_err === 1'b1) obs_q.push_back('{1'b1, 8'h00, 1'b0, 1'b0, cyc});
        if (rx_busy === 1'b1) busy_cycles <= busy_cycles + 1;
        if (key_valid === 1'b1 && frame_err === 1'b1) both_cnt <= both_cnt + 1;
    end

    int total = 0;
    int bad = 0;
    bit m_ext = 1'b0;
    bit m_brk = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives the first nfalls bits of a frame; data changes only while ps2_clk is high.
    task automatic send_bits(input logic [7:0] b, input logic par_flip, input logic stop_v,
                             input int nfalls, output int last_fall);
        logic [10:0] fr;
        fr = {stop_v, (~^b) ^ par_flip, b, 1'b0};
        last_fall = cyc;
        for (int i = 0; i < nfalls; i++) begin
            ps2_data = fr[i];
            wait_cyc(HP);
            ps2_clk = 1'b0;
            last_fall = cyc;
            wait_cyc(HP);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input logic par_flip, input logic stop_bad,
                            input string tag);
        int base;
        int last;
        bit exp_key;
        bit exp_err;
        logic ebrk;
        logic eext;
        ev_t e;
        exp_err = par_flip | stop_bad;
        exp_key = 1'b0;
        ebrk = 1'b0;
        eext = 1'b0;
        if (exp_err) begin
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            exp_key = 1'b1;
            ebrk = m_brk;
            eext = m_ext;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
        base = obs_q.size();
        send_bits(b, par_flip, ~stop_bad, 11, last);
        wait_cyc(3 * HP);
        check({tag, ".events"}, obs_q.size() - base, (exp_key || exp_err) ? 1 : 0);
        if (obs_q.size() > base) begin
            e = obs_q[base];
            check({tag, ".is_err"}, e.is_err, exp_err);
            check({tag, ".latency"}, e.at - last, LAT);
            if (exp_key) begin
                check({tag, ".code"}, e.code, b);
                check({tag, ".break"}, e.brk, ebrk);
                check({tag, ".ext"}, e.ext, eext);
            end
        end
        check({tag, ".idle_busy"}, rx_busy, 1'b0);
    endtask

    initial begin
        int base;
        int last;
        int busy0;
        int waited;
        logic [7:0] b;
        int r;

        reset = 1'b0;
        wait_cyc(5);
        check("rst.key_valid", key_valid, 1'b0);
        check("rst.key_code", key_code, 8'h00);
        check("rst.key_break", key_break, 1'b0);
        check("rst.key_extended", key_extended, 1'b0);
        check("rst.frame_err", frame_err, 1'b0);
        check("rst.rx_busy", rx_busy, 1'b0);
        reset = 1'b1;
        wait_cyc(20);

        do_frame(8'h1D, 1'b0, 1'b0, "make");
        do_frame(8'hF0, 1'b0, 1'b0, "brk_pre");
        do_frame(8'h1D, 1'b0, 1'b0, "brk");
        do_frame(8'hE0, 1'b0, 1'b0, "ext_pre");
        do_frame(8'hF0, 1'b0, 1'b0, "ext_brk_pre");
        do_frame(8'h75, 1'b0, 1'b0, "ext_brk");
        do_frame(8'h1C, 1'b0, 1'b0, "after_ext");
        check("hold.key_code", key_code, 8'h1C);
        do_frame(8'h1D, 1'b1, 1'b0, "parity");
        do_frame(8'h1C, 1'b0, 1'b0, "after_par");
        do_frame(8'hF0, 1'b0, 1'b0, "pend_pre");
        do_frame(8'hF0, 1'b0, 1'b0, "pend_pre2");
        do_frame(8'h1D, 1'b1, 1'b0, "pend_par");
        do_frame(8'h1C, 1'b0, 1'b0, "pend_clr");
        do_frame(8'h2A, 1'b0, 1'b1, "stop_bad");

        // Timeout: abandon a frame after 5 falls with a break prefix pending.
        do_frame(8'hF0, 1'b0, 1'b0, "to_pre");
        base = obs_q.size();
        send_bits(8'h00, 1'b0, 1'b1, 5, last);
        check("to.busy_mid", rx_busy, 1'b1);
        waited = 0;
        while (obs_q.size() == base && waited < TO + 200) begin
            wait_cyc(1);
            waited++;
        end
        m_ext = 1'b0;
        m_brk = 1'b0;
        check("to.events", obs_q.size() - base, 1);
        if (obs_q.size() > base) begin
            check("to.is_err", obs_q[base].is_err, 1'b1);
            check("to.latency", obs_q[base].at - last, TO + SYNC + FILT);
        end
        wait_cyc(2);
        check("to.idle", rx_busy, 1'b0);
        do_frame(8'h1C, 1'b0, 1'b0, "after_to");

        for (int g = 1; g < FILT; g++) begin
            base = obs_q.size();
            busy0 = busy_cycles;
            wait_cyc(5);
            ps2_clk = 1'b0;
            wait_cyc(g);
            ps2_clk = 1'b1;
            wait_cyc(30);
            check("glitch.events", obs_q.size() - base, 0);
            check("glitch.busy", busy_cycles - busy0, 0);
        end

        // Reset during bit 4 of 0x1D with a break prefix pending.
        do_frame(8'hF0, 1'b0, 1'b0, "rst_pre");
        base = obs_q.size();
        send_bits(8'h1D, 1'b0, 1'b1, 4, last);
        ps2_data = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(1);
        check("midrst.key_code", key_code, 8'h00);
        check("midrst.rx_busy", rx_busy, 1'b0);
        check("midrst.key_valid", key_valid, 1'b0);
        check("midrst.frame_err", frame_err, 1'b0);
        check("midrst.key_break", key_break, 1'b0);
        reset = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
        wait_cyc(3 * HP);
        check("midrst.events", obs_q.size() - base, 0);
        do_frame(8'h1D, 1'b0, 1'b0, "post_rst");

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else b = 8'($urandom_range(0, 255));
            r = $urandom_range(0, 9);
            do_frame(b, (r == 0), (r == 1), "rand");
        end

        check("never_both", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_key_receiver.md
# ps2_key_receiver

Synthesizable PS/2 keyboard receiver in the tetris_top input path. It sits directly downstream of the keyboard pins, which the PS/2 keyboard driver VIP drives in simulation. It deserializes device-to-host frames, checks framing, folds the 0xE0 (extended) and 0xF0 (break) prefixes, and emits one key event per make/break code to the game controller. It only listens and never drives ps2_clk or ps2_data.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops per PS/2 input.
- FILTER_CYCLES, 4: consecutive equal samples before the filtered ps2_clk level changes.
  - Must satisfy SYNC_STAGES+FILTER_CYCLES+2 < PS/2 half-period in clk cycles.
- TIMEOUT_CYCLES, 20000: maximum clk cycles between falling edges inside a frame.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- ps2_clk  in  1  PS/2 clock line (asynchronous, pulled up).
- ps2_data  in  1  PS/2 data line (asynchronous, pulled up).
- key_valid  out  1  one-cycle pulse; key event fields are valid.
- key_code  out  8  scan code, prefixes stripped; held until the next event.
- key_break  out  1  1 = release (0xF0 seen), 0 = press.
- key_extended  out  1  1 = 0xE0 prefix seen.
- frame_err  out  1  one-cycle pulse on bad start, parity, stop, or timeout.
- rx_busy  out  1  high while a frame is in progress (state SHIFT).

## Operation
- ps2_clk and ps2_data each pass through SYNC_STAGES flops.
- Synchronized ps2_clk feeds a glitch filter. The filtered level changes only after FILTER_CYCLES identical samples.
- A falling edge of the filtered clock is a 1-cycle strobe, fall_stb. On fall_stb the receiver samples synchronized ps2_data.
- FSM states: IDLE, SHIFT, CHECK.
  - IDLE: on fall_stb with data=0 (start bit), go to SHIFT with bit_cnt=1. On fall_stb with data=1, pulse frame_err and stay in IDLE.
  - SHIFT: each fall_stb shifts data in LSB-first.
    - bit_cnt 1..8 are data bits, 9 is parity, 10 is stop.
    - After the stop bit, go to CHECK.
    - A timeout counter clears on each fall_stb. If it reaches TIMEOUT_CYCLES, pulse frame_err, clear prefix flags, and go to IDLE.
  - CHECK (one cycle): the frame is good if parity is odd (^{data,parity}==1) and stop==1.
    - Bad frame: pulse frame_err and clear both prefix flags.
    - Good byte 0xE0: set ext_pend.
    - Good byte 0xF0: set brk_pend.
    - Any other good byte: pulse key_valid with key_code=byte, key_break=brk_pend, key_extended=ext_pend; then clear both pend flags.
    - Always return to IDLE.
- Repeated prefixes (e.g. F0 F0) keep the flag set; this is not an error.
- Reset values: all outputs 0, state IDLE, bit_cnt 0, shift register 0, pend flags 0, filtered clock 1, synchronizers 1.
- Reset asserted mid-frame aborts with no key_valid or frame_err, and discards pending prefixes.

## Timing
- key_valid or frame_err for a completed frame asserts exactly SYNC_STAGES+FILTER_CYCLES+2 clk cycles after the stop-bit falling edge at the ps2_clk pin. This assumes a glitch-free pin.
- key_valid and frame_err are never high in the same cycle. Each is high for exactly one cycle.
- rx_busy rises the cycle after the start-bit fall_stb and falls on entry to CHECK.
- ps2_clk pulses shorter than FILTER_CYCLES cycles produce no fall_stb.
- Timeout is measured only in SHIFT. Time spent in IDLE is unbounded.
- No backpressure: the consumer must accept key_valid in the cycle it is high.

## Structure
- Package ps2_pkg holds:
  - the rx_state_e enum (IDLE, SHIFT, CHECK);
  - localparams PS2_EXT_PREFIX=8'hE0, PS2_BRK_PREFIX=8'hF0, PS2_FRAME_BITS=11.
- Sub-module ps2_line_filter (parameters SYNC_STAGES, FILTER_CYCLES; ports clk, reset, din, dout, fall_stb). One instance serves ps2_clk.
- ps2_data uses a plain synchronizer of the same depth, keeping both lines aligned.

## Test plan
- Make code: send 0x1D (W) → one key_valid, key_code=0x1D, key_break=0, key_extended=0, no frame_err.
- Break sequence: send F0,1D → exactly one key_valid, key_code=0x1D, key_break=1. The F0 byte alone produces no key_valid.
- Extended break: send E0,F0,75 (up-arrow release) → key_code=0x75, key_extended=1, key_break=1. The following byte 0x1C gives key_extended=0, key_break=0.
- Parity error: send 0x1D with parity forced to 0 → frame_err pulse, no key_valid. A following good 0x1C decodes normally, with a prefix cleared if one was pending.
- Timeout and glitch:
  - Stop toggling ps2_clk after 5 bits → frame_err exactly TIMEOUT_CYCLES after the last fall_stb, state IDLE.
  - A 2-cycle low glitch on idle ps2_clk → no rx_busy, no events.
- Reset mid-frame: drive reset low for 1 cycle during bit 4 of 0x1D → all outputs 0, no pulses. The next full 0x1D frame decodes with exactly SYNC_STAGES+FILTER_CYCLES+2 latency.
